// File: rtl/quadrilatero_obi_responder_if.sv
// Bus bundle for the four quadrilatero OBI channels.
// Each field is a packed array with one element per channel, indexed by channel number.
//
// Request (master -> responder):
//   req, we, be[3:0], addr[31:0], wdata[31:0]
// Response (responder -> master):
//   gnt, rvalid, rdata[31:0]
//
// Modports:
//   master - the requesting side (quadrilatero core, bridge, or testbench)
//   slave  - the responder
interface quadrilatero_obi_responder_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       we;
  logic [NUM_CH-1:0][3:0]  be;
  logic [NUM_CH-1:0][31:0] addr;
  logic [NUM_CH-1:0][31:0] wdata;
  logic [NUM_CH-1:0]       gnt;
  logic [NUM_CH-1:0]       rvalid;
  logic [NUM_CH-1:0][31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/quadrilatero_obi_responder.sv
// Four-channel OBI responder acting as a fixed-latency matrix scratchpad.
// Channel k owns a private bank of 32-bit words. That bank holds lane k of every
// 128-bit quadrilatero beat, i.e. the words with addr[3:2] == k.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   ch           quadrilatero_obi_responder_if.slave, one OBI channel per bank
//   misrouted_o  sticky per-channel flag: a granted access had addr[3:2] != k
//   clr_flags_i  synchronous clear of misrouted_o; a simultaneous set wins
//
// Parameters:
//   NUM_CH      number of channels/banks (4, one per 128-bit lane)
//   BANK_DEPTH  words per bank, power of two, >= 2
//   LATENCY     cycles from accept to rvalid, 1..4
//   STALL_SEED  LFSR seed base for the optional random stall generator
//
// Optional feature:
//   QUADRILATERO_OBI_RESP_STALL_EN adds a per-channel 8-bit LFSR that withholds gnt
//   in about 25% of cycles. When the macro is not defined, gnt follows req.
module quadrilatero_obi_responder #(
  parameter int         NUM_CH     = 4,
  parameter int         BANK_DEPTH = 1024,
  parameter int         LATENCY    = 1,
  parameter logic [7:0] STALL_SEED = 8'hA5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  quadrilatero_obi_responder_if.slave ch,
  output logic [NUM_CH-1:0]          misrouted_o,
  input  logic                       clr_flags_i
);

  localparam int IDX_W = $clog2(BANK_DEPTH);

  logic [NUM_CH-1:0]       gnt_w;
  logic [NUM_CH-1:0]       rvalid_w;
  logic [NUM_CH-1:0][31:0] rdata_w;

  assign ch.gnt    = gnt_w;
  assign ch.rvalid = rvalid_w;
  assign ch.rdata  = rdata_w;

`ifndef QUADRILATERO_OBI_RESP_STALL_EN
  logic [7:0] unused_stall_seed;
  assign unused_stall_seed = STALL_SEED;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic             stall;
    logic             acc;
    logic             misroute;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem [BANK_DEPTH];
    logic [31:0]      ram_q;
    logic             wr_q;
    logic [31:0]      d0;
    logic [LATENCY-1:0] vld_q;
    logic             mis_q;
    logic             unused_addr_bits;

`ifdef QUADRILATERO_OBI_RESP_STALL_EN
    localparam logic [7:0] SEED_RAW = STALL_SEED ^ 8'(k);
    localparam logic [7:0] SEED     = (SEED_RAW == 8'h00) ? 8'h01 : SEED_RAW;

    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_lfsr
      if (!rst_ni) begin
        lfsr_q <= SEED;
      end else begin
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // gnt is forced low while reset is asserted so nothing can be accepted then
    assign gnt_w[k]  = ch.req[k] & ~stall & rst_ni;
    assign acc       = ch.req[k] & gnt_w[k];
    assign idx       = ch.addr[k][4 +: IDX_W];
    assign misroute  = (ch.addr[k][3:2] != 2'(k));
    assign unused_addr_bits = ^{ch.addr[k][31:4+IDX_W], ch.addr[k][1:0]};

    // Single-port synchronous bank, no reset on contents
    always_ff @(posedge clk_i) begin : p_bank
      if (acc) begin
        if (ch.we[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (ch.be[k][b]) begin
              mem[idx][8*b +: 8] <= ch.wdata[k][8*b +: 8];
            end
          end
        end else begin
          ram_q <= mem[idx];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_ctrl
      if (!rst_ni) begin
        vld_q <= '0;
        wr_q  <= 1'b1;
        mis_q <= 1'b0;
      end else begin
        vld_q[0] <= acc;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
        if (acc) begin
          wr_q <= ch.we[k];
        end
        if (acc && misroute) begin
          mis_q <= 1'b1;
        end else if (clr_flags_i) begin
          mis_q <= 1'b0;
        end
      end
    end

    // wr_q resets to 1 so the first response stage reads as zero out of reset,
    // without needing a reset on the RAM output register. Both wr_q and ram_q
    // only change on an accept, so d0 is stable whenever the first stage is idle.
    assign d0 = wr_q ? 32'h0 : ram_q;

    assign rvalid_w[k]  = vld_q[LATENCY-1];
    assign misrouted_o[k] = mis_q;

    if (LATENCY == 1) begin : g_direct
      assign rdata_w[k] = d0;
    end else begin : g_pipe
      // pipe_q[j] carries the data that belongs to vld_q[j+1]; a stage only
      // loads when its predecessor is valid, so rdata holds between responses.
      logic [31:0] pipe_q [LATENCY-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin : p_pipe
        if (!rst_ni) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_q[i] <= 32'h0;
          end
        end else begin
          if (vld_q[0]) begin
            pipe_q[0] <= d0;
          end
          for (int i = 1; i < LATENCY - 1; i++) begin
            if (vld_q[i]) begin
              pipe_q[i] <= pipe_q[i-1];
            end
          end
        end
      end

      assign rdata_w[k] = pipe_q[LATENCY-2];
    end
  end

endmodule

// File: tb/tb_quadrilatero_obi_responder.sv
// Testbench for quadrilatero_obi_responder.
// Two instances are used: dut1 (LATENCY=1) and dut3 (LATENCY=3).
// Directed stimulus pushes hand-computed responses (data and due cycle) into
// per-channel queues. A negedge monitor pops the queue entry and compares it
// whenever rvalid is high, and checks that rdata holds whenever rvalid is low.
module tb_quadrilatero_obi_responder;

  logic       clk = 1'b0;
  logic       rst1_n, rst3_n;
  logic       clr1, clr3;
  logic [3:0] mis1, mis3;

  always #5 clk = ~clk;

  quadrilatero_obi_responder_if #(.NUM_CH(4)) bus1 ();
  quadrilatero_obi_responder_if #(.NUM_CH(4)) bus3 ();

  quadrilatero_obi_responder #(.NUM_CH(4), .BANK_DEPTH(1024), .LATENCY(1), .STALL_SEED(8'hA5)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .ch(bus1), .misrouted_o(mis1), .clr_flags_i(clr1)
  );

  quadrilatero_obi_responder #(.NUM_CH(4), .BANK_DEPTH(1024), .LATENCY(3), .STALL_SEED(8'hA5)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .ch(bus3), .misrouted_o(mis3), .clr_flags_i(clr3)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q [8][$];
  logic [31:0] last_exp [8];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic set_ch(input int d, input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
    if (d == 0) begin
      bus1.req[k] = r; bus1.we[k] = w; bus1.addr[k] = a; bus1.wdata[k] = wd; bus1.be[k] = b;
    end else begin
      bus3.req[k] = r; bus3.we[k] = w; bus3.addr[k] = a; bus3.wdata[k] = wd; bus3.be[k] = b;
    end
  endtask

  // Drive one request for the coming edge; the response is due LATENCY cycles later.
  task automatic issue(input int d, input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       input logic [31:0] exp_data, input bit expect_rsp);
    exp_t e;
    set_ch(d, k, 1'b1, w, a, wd, b);
    if (expect_rsp) begin
      e.data = exp_data;
      e.cyc  = cyc + lat(d);
      exp_q[d*4+k].push_back(e);
    end
  endtask

  // Check gnt for all raised requests, advance one clock, release requests.
  task automatic tick();
    logic r, g;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        r = (d == 0) ? bus1.req[k] : bus3.req[k];
        g = (d == 0) ? bus1.gnt[k] : bus3.gnt[k];
        if (r) chk($sformatf("gnt_d%0d_ch%0d", d, k), {31'h0, g}, 32'h1);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) set_ch(d, k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        int          q;
        logic        v, rstn;
        logic [31:0] rd;
        exp_t        e;
        q    = d * 4 + k;
        v    = (d == 0) ? bus1.rvalid[k] : bus3.rvalid[k];
        rd   = (d == 0) ? bus1.rdata[k]  : bus3.rdata[k];
        rstn = (d == 0) ? rst1_n : rst3_n;
        if (!rstn) last_exp[q] = 32'h0;
        if (v) begin
          if (exp_q[q].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid d%0d ch%0d cycle=%0d actual=1 required=0", d, k, cyc);
          end else begin
            e = exp_q[q].pop_front();
            chk($sformatf("rdata_d%0d_ch%0d", d, k), rd, e.data);
            chk($sformatf("rvalid_cycle_d%0d_ch%0d", d, k), cyc, e.cyc);
            last_exp[q] = e.data;
          end
        end else begin
          chk($sformatf("rdata_hold_d%0d_ch%0d", d, k), rd, last_exp[q]);
        end
      end
    end
  end

  logic [31:0] ind_val [4];

  initial begin
    ind_val = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    for (int q = 0; q < 8; q++) last_exp[q] = 32'h0;
    rst1_n = 1'b0; rst3_n = 1'b0; clr1 = 1'b0; clr3 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) set_ch(d, k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end

    // Reset state: gnt held low even with req raised
    set_ch(0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_ch(1, 2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt_d0", {28'h0, bus1.gnt}, 32'h0);
    chk("reset_gnt_d1", {28'h0, bus3.gnt}, 32'h0);
    chk("reset_mis_d0", {28'h0, mis1}, 32'h0);
    chk("reset_mis_d1", {28'h0, mis3}, 32'h0);
    set_ch(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_ch(1, 2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst1_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then back-to-back read on ch2
    issue(0, 2, 1'b1, 32'h28, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);          tick();
    issue(0, 2, 1'b0, 32'h28, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);          tick();

    // Byte enables
    issue(0, 2, 1'b1, 32'h38, 32'h1122_3344, 4'hF, 32'h0, 1'b1);          tick();
    issue(0, 2, 1'b1, 32'h38, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b1);       tick();
    issue(0, 2, 1'b0, 32'h38, 32'h0, 4'h0, 32'h11BB_33DD, 1'b1);          tick();

    // Independence: all channels at once
    for (int k = 0; k < 4; k++) issue(0, k, 1'b1, 32'(4*k), ind_val[k], 4'hF, 32'h0, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) issue(0, k, 1'b0, 32'(4*k), 32'h0, 4'h0, ind_val[k], 1'b1);
    tick();
    chk("mis_clean", {28'h0, mis1}, 32'h0);

    // Misroute: ch1 reads lane 0 address, bank1 index 0 is served
    issue(0, 1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2222_0001, 1'b1);           tick();
    chk("mis_set", {28'h0, mis1}, 32'h2);
    idle(1);
    chk("mis_sticky", {28'h0, mis1}, 32'h2);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("mis_clr", {28'h0, mis1}, 32'h0);
    // set and clear in the same cycle: set wins
    issue(0, 3, 1'b0, 32'h0, 32'h0, 4'h0, 32'h4444_0003, 1'b1);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("mis_set_wins", {28'h0, mis1}, 32'h8);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("mis_clr2", {28'h0, mis1}, 32'h0);

    // Upper-bit alias and ignored addr[1:0]
    issue(0, 0, 1'b1, 32'h0000_4010, 32'h1234_5678, 4'hF, 32'h0, 1'b1);   tick();
    issue(0, 0, 1'b0, 32'h0000_0013, 32'h0, 4'h0, 32'h1234_5678, 1'b1);   tick();

    // be=0 write leaves the word untouched
    issue(0, 3, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b1);           tick();
    issue(0, 3, 1'b0, 32'hC, 32'h0, 4'h0, 32'h4444_0003, 1'b1);           tick();
    idle(2);

    // LATENCY=3 pipelining: preload idx 0..3, then 4 back-to-back reads
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 1'b1, 32'(16*i), 32'(i), 4'hF, 32'h0, 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 1'b0, 32'(16*i), 32'h0, 4'h0, 32'(i), 1'b1);
      tick();
    end
    idle(4);

    // Reset mid-flight on dut3
    issue(1, 1, 1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);          tick();
    idle(4);
    issue(1, 1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h0, 1'b0);                  tick();
    rst3_n = 1'b0;
    set_ch(1, 1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    #1;
    chk("gnt_in_reset", {31'h0, bus3.gnt[1]}, 32'h0);
    set_ch(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(2);
    rst3_n = 1'b1;
    idle(6);
    issue(1, 1, 1'b0, 32'h14, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);          tick();
    idle(6);

    chk("mis_d1_end", {28'h0, mis3}, 32'h0);
    for (int q = 0; q < 8; q++) chk($sformatf("pending_q%0d", q), 32'(exp_q[q].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
